uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the counterpart of the system's UART transmitter. It deserialises one 11-bit frame from the rx line: start 0, 8 data bits LSB first, even parity bit (XOR of data), stop 1. It presents the byte, a one-cycle valid strobe and a sticky flag to the memory-mapped UART peripheral on the RISC-V bus. Error status bits report parity, framing and overrun errors.

Parameters:
BIT_CLKS, 5210, clk cycles per bit (9600 baud at 50 MHz); simulation builds use 10.
HALF_CLKS, BIT_CLKS/2, clk cycles from start-edge detection to the start-bit mid-point check.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
rx  input  1  serial line, asynchronous to clk, idles high.
clr_rx_flag  input  1  synchronous clear of rx_flag and overrun_error.
rx_data  output  8  last received byte, held until the next frame completes.
rx_valid  output  1  one-cycle pulse when a frame completes.
rx_flag  output  1  sticky "byte available"; set on completion, cleared by clr_rx_flag.
parity_error  output  1  status of the last frame: received parity differs from ^rx_data.
framing_error  output  1  status of the last frame: stop bit sampled 0.
overrun_error  output  1  sticky: a frame completed while rx_flag was already 1.
rx_state  output  3  current FSM state, for debug.

Behaviour:
- Reset (n_rst=0, asynchronous): all outputs 0, state IDLE, sync flops 1, timer and bit count 0.
- Input sync: 2-flop synchroniser gives rx_s; a previous-value flop gives rx_s_d. All decisions use rx_s only.
- Timer: counts 0..BIT_CLKS-1 and is cleared on every state entry. "tick" = timer==BIT_CLKS-1; "half" = timer==HALF_CLKS-1.
- States and encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Codes 5-7 go to IDLE on the next clk.
- IDLE: rx_s_d=1 and rx_s=0 (falling edge) -> START. A line held low never triggers.
- START: on half, rx_s=0 -> DATA; rx_s=1 -> IDLE as a glitch/false start, with no output change.
- DATA: on each tick, shift right with rx_s into bit 7 and increment the bit count. On the 8th sample, clear the count and go to PARITY.
- PARITY: on tick, store rx_s as par_bit, then go to STOP.
- STOP: on tick, in a single cycle:
  - rx_data <= shift reg;
  - parity_error <= par_bit ^ (^shift reg);
  - framing_error <= ~rx_s;
  - rx_valid=1 for exactly this cycle;
  - overrun_error set if rx_flag was already 1;
  - rx_flag <= 1;
  - go to IDLE.
- Framing error: the byte is still delivered. IDLE requires rx_s to return high before a new edge is accepted.
- Simultaneous events: frame completion and clr_rx_flag in the same cycle leave rx_flag=1. clr_rx_flag clears overrun_error unless an overrun occurs in that same cycle.
- Latency: rx_valid is high in the cycle 2 + HALF_CLKS + 10*BIT_CLKS clk edges after the first clk edge that samples rx=0. For BIT_CLKS=10 this is 107.
- Bit sampling: each data, parity and stop sample is taken at mid-bit ± 1 clk.
- Reset mid-frame: everything returns to reset values immediately. A partial frame produces no rx_valid.

Decomposition:
- Shared UART include/package holds the state codes (IDLE..STOP), the frame constants (8 data bits, even parity) and the BIT_CLKS defaults (5210 synthesis, 10 under the RISCV_SIM_ONLY define). The same constants are used by the transmitter.
- One natural sub-module: uart_rx_bit_timer (counter with clear; outputs tick and half).
- The synchroniser and FSM stay in uart_rx.

Test Plan (BIT_CLKS=10):
1. Drive frame 0x55 with parity 0 and stop 1 -> rx_valid for 1 cycle at edge+107; rx_data=0x55; rx_flag=1; parity_error=0; framing_error=0.
2. Drive 0xA7 with a wrong parity bit (0) -> rx_data=0xA7, parity_error=1. Then drive a clean 0x01 (parity 1) -> parity_error returns to 0.
3. Drive 0x3C with stop bit 0, then hold rx=0 for 30 cycles, then idle -> framing_error=1 and a single rx_valid. No second frame starts until rx returns high.
4. Drive a 3-cycle low glitch on an idle line -> FSM goes START then back to IDLE; rx_valid never asserts; outputs unchanged.
5. Receive two frames without pulsing clr_rx_flag -> overrun_error=1 after the second. Pulse clr_rx_flag -> rx_flag=0 and overrun_error=0. Also assert clr_rx_flag exactly in a completion cycle -> rx_flag stays 1.
6. Assert n_rst low during the DATA state of a frame -> all outputs 0 immediately. After release with a 2-cycle idle line, the next full 0xFF frame (parity 0) is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and state codes shared by the UART receiver and transmitter.
//   DATA_BITS         - data bits per frame (sent LSB first)
//   PARITY_EVEN       - 1: parity bit is XOR of the data bits
//   BIT_CLKS_DEFAULT  - clk cycles per bit; short value for simulation builds
//   uart_state_e      - FSM state codes, also exported on the debug port
package uart_rx_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        PARITY_EVEN = 1'b1;

`ifdef RISCV_SIM_ONLY
    localparam int unsigned BIT_CLKS_DEFAULT = 10;
`else
    localparam int unsigned BIT_CLKS_DEFAULT = 5210;  // 9600 baud at 50 MHz
`endif

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: free-running bit-period counter, restarted by i_clr.
//   clk, n_rst - clock and asynchronous active-low reset
//   i_clr      - restart the count at 0 on the next edge
//   o_tick     - count is at the last cycle of a bit period
//   o_half     - count is at the last cycle of a half bit period
module uart_rx_bit_timer #(
    parameter int unsigned BIT_CLKS  = 10,
    parameter int unsigned HALF_CLKS = BIT_CLKS / 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clr,
    output logic o_tick,
    output logic o_half
);

    localparam int unsigned CntW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == CntW'(BIT_CLKS - 1));
    assign o_half = (r_cnt == CntW'(HALF_CLKS - 1));

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 11-bit frames (start, 8 data LSB first, even parity, stop).
//   clk, n_rst     - clock and asynchronous active-low reset
//   rx             - asynchronous serial input, idles high
//   clr_rx_flag    - clears rx_flag and overrun_error
//   rx_data        - last received byte
//   rx_valid       - one-cycle strobe on frame completion
//   rx_flag        - sticky byte-available flag
//   parity_error   - parity mismatch on the last frame
//   framing_error  - stop bit was 0 on the last frame
//   overrun_error  - sticky: frame completed while rx_flag was still set
//   rx_state       - current FSM state (debug)
import uart_rx_pkg::*;

module uart_rx #(
    parameter int unsigned BIT_CLKS  = BIT_CLKS_DEFAULT,
    parameter int unsigned HALF_CLKS = BIT_CLKS / 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx,
    input  logic                 clr_rx_flag,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_flag,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic [2:0]           rx_state
);

    localparam int unsigned BcntW = $clog2(DATA_BITS);

    logic                 r_sync1, r_rx_s, r_rx_s_d;
    uart_state_e          r_state, w_state_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic [BcntW-1:0]     r_bcnt, w_bcnt_d;
    logic                 r_par, w_par_d;
    logic                 w_done;
    logic                 w_tick, w_half, w_tmr_clr;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_flag, r_perr, r_ferr, r_ovr;

    // Timer restarts on every state change so each state measures from its own entry.
    assign w_tmr_clr = (w_state_d != r_state);

    uart_rx_bit_timer #(
        .BIT_CLKS  (BIT_CLKS),
        .HALF_CLKS (HALF_CLKS)
    ) u_bit_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clr  (w_tmr_clr),
        .o_tick (w_tick),
        .o_half (w_half)
    );

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_bcnt_d  = r_bcnt;
        w_par_d   = r_par;
        w_done    = 1'b0;
        case (r_state)
            StIdle: begin
                // Falling edge only; a line stuck low never starts a frame.
                if (r_rx_s_d && !r_rx_s) w_state_d = StStart;
            end
            StStart: begin
                if (w_half) w_state_d = r_rx_s ? StIdle : StData;
            end
            StData: begin
                if (w_tick) begin
                    w_shift_d = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    if (r_bcnt == BcntW'(DATA_BITS - 1)) begin
                        w_bcnt_d  = '0;
                        w_state_d = StParity;
                    end else begin
                        w_bcnt_d = r_bcnt + 1'b1;
                    end
                end
            end
            StParity: begin
                if (w_tick) begin
                    w_par_d   = r_rx_s;
                    w_state_d = StStop;
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_done    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
            r_state  <= StIdle;
            r_shift  <= '0;
            r_bcnt   <= '0;
            r_par    <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_flag   <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
            r_state  <= w_state_d;
            r_shift  <= w_shift_d;
            r_bcnt   <= w_bcnt_d;
            r_par    <= w_par_d;
            r_valid  <= w_done;
            if (w_done) begin
                r_data <= r_shift;
                r_perr <= r_par ^ (^r_shift) ^ ~PARITY_EVEN;
                r_ferr <= ~r_rx_s;
            end
            // Completion wins over a simultaneous clear.
            if (w_done)           r_flag <= 1'b1;
            else if (clr_rx_flag) r_flag <= 1'b0;
            if (w_done && r_flag) r_ovr <= 1'b1;
            else if (clr_rx_flag) r_ovr <= 1'b0;
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_flag       = r_flag;
    assign parity_error  = r_perr;
    assign framing_error = r_ferr;
    assign overrun_error = r_ovr;
    assign rx_state      = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx with BIT_CLKS=10.
module tb_uart_rx;

    localparam int B       = 10;
    localparam int LATENCY = 107;  // edges from first edge sampling the start bit

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rx_line = 1'b1;
    logic       clr_rx_flag = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_flag, parity_error, framing_error, overrun_error;
    logic [2:0] rx_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model state: sticky flags as seen by software.
    bit m_flag = 1'b0;
    bit m_ovr  = 1'b0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr, ferr, flag, ovr;
    } rec_t;
    rec_t q[$];

    uart_rx #(
        .BIT_CLKS (B)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx            (rx_line),
        .clr_rx_flag   (clr_rx_flag),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_flag       (rx_flag),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .rx_state      (rx_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            q.push_back('{cyc: cyc, data: rx_data, perr: parity_error, ferr: framing_error,
                          flag: rx_flag, ovr: overrun_error});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bit-bang one frame; leaves rx at the stop level. clr_done pulses clr_rx_flag
    // exactly in the completion cycle.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit clr_done, output int start);
        logic [10:0] bits;
        bits  = {stop, par, d, 1'b0};
        start = cyc;
        for (int m = 0; m < 11 * B; m++) begin
            rx_line     = bits[m / B];
            clr_rx_flag = clr_done && (m == LATENCY);
            step(1);
        end
        clr_rx_flag = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic par,
                                input logic stop, input int start, input bit clr_done);
        rec_t r;
        int   waited = 0;
        bit   exp_perr;
        while (q.size() == 0 && waited < 30) begin
            step(1);
            waited++;
        end
        if (q.size() == 0) begin
            check_eq({tag, " valid timeout"}, 32'(q.size()), 32'd1);
            return;
        end
        r = q.pop_front();
        exp_perr = (par != ($countones(d) % 2 == 1));
        m_ovr  = m_flag ? 1'b1 : (clr_done ? 1'b0 : m_ovr);
        m_flag = 1'b1;
        check_eq({tag, " latency"}, 32'(r.cyc - start), 32'(LATENCY + 1));
        check_eq({tag, " data"}, 32'(r.data), 32'(d));
        check_eq({tag, " parity_error"}, 32'(r.perr), 32'(exp_perr));
        check_eq({tag, " framing_error"}, 32'(r.ferr), 32'(!stop));
        check_eq({tag, " rx_flag"}, 32'(r.flag), 32'(m_flag));
        check_eq({tag, " overrun"}, 32'(r.ovr), 32'(m_ovr));
        step(1);
        check_eq({tag, " single valid"}, 32'(q.size()), 32'd0);
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input logic par,
                         input logic stop, input bit clr_done);
        int start;
        send_frame(d, par, stop, clr_done, start);
        expect_frame(tag, d, par, stop, start, clr_done);
    endtask

    task automatic pulse_clr();
        clr_rx_flag = 1'b1;
        step(1);
        clr_rx_flag = 1'b0;
        m_flag = 1'b0;
        m_ovr  = 1'b0;
        check_eq("clr rx_flag", 32'(rx_flag), 32'(m_flag));
        check_eq("clr overrun", 32'(overrun_error), 32'(m_ovr));
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    initial begin
        logic [12:0] snap;
        int          start;

        // Reset
        step(3);
        check_eq("reset outputs",
                 32'({rx_data, rx_valid, rx_flag, parity_error, framing_error, overrun_error,
                      rx_state}), 32'd0);
        n_rst = 1'b1;
        step(5);

        // 1: clean 0x55
        frame("t1 0x55", 8'h55, 1'b0, 1'b1, 1'b0);
        step(5);

        // 2: bad parity then good parity
        pulse_clr();
        frame("t2 0xA7 badpar", 8'hA7, 1'b0, 1'b1, 1'b0);
        step(5);
        frame("t2 0x01", 8'h01, 1'b1, 1'b1, 1'b0);
        step(5);

        // 3: stop bit 0, line held low afterwards
        pulse_clr();
        send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b0, start);
        rx_line = 1'b0;
        expect_frame("t3 0x3C framing", 8'h3C, even_par(8'h3C), 1'b0, start, 1'b0);
        step(30);
        check_eq("t3 held low idle", 32'(rx_state), 32'd0);
        check_eq("t3 no new frame", 32'(q.size()), 32'd0);
        rx_line = 1'b1;
        step(5);

        // 4: 3-cycle glitch
        snap = {rx_data, rx_flag, parity_error, framing_error, overrun_error};
        rx_line = 1'b0;
        step(3);
        rx_line = 1'b1;
        check_eq("t4 glitch start", 32'(rx_state), 32'd1);
        step(20);
        check_eq("t4 back idle", 32'(rx_state), 32'd0);
        check_eq("t4 no valid", 32'(q.size()), 32'd0);
        check_eq("t4 outputs held",
                 32'({rx_data, rx_flag, parity_error, framing_error, overrun_error}), 32'(snap));

        // 5: overrun and clear collisions
        pulse_clr();
        frame("t5 a", 8'h12, even_par(8'h12), 1'b1, 1'b0);
        step(4);
        frame("t5 b overrun", 8'h34, even_par(8'h34), 1'b1, 1'b0);
        step(4);
        pulse_clr();
        frame("t5 c clr@done", 8'h56, even_par(8'h56), 1'b1, 1'b1);
        step(4);
        frame("t5 d clr@done ovr", 8'h78, even_par(8'h78), 1'b1, 1'b1);
        step(4);

        // Randomized frames
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic       par, stop;
            bit         clr_done;
            d        = 8'($urandom_range(0, 255));
            par      = even_par(d) ^ ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 4) != 0);
            clr_done = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) pulse_clr();
            frame("rand", d, par, stop, clr_done);
            rx_line = 1'b1;
            step($urandom_range(3, 15));
        end

        // 6: reset during DATA
        start = cyc;
        for (int m = 0; m < 4 * B; m++) begin
            rx_line = (m < B) ? 1'b0 : 1'b1;
            step(1);
        end
        check_eq("t6 in data", 32'(rx_state), 32'd2);
        n_rst = 1'b0;
        #1;
        check_eq("t6 async reset",
                 32'({rx_data, rx_valid, rx_flag, parity_error, framing_error, overrun_error,
                      rx_state}), 32'd0);
        m_flag  = 1'b0;
        m_ovr   = 1'b0;
        rx_line = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        step(2);
        check_eq("t6 no partial valid", 32'(q.size()), 32'd0);
        frame("t6 0xFF", 8'hFF, 1'b0, 1'b1, 1'b0);
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
